// File: rtl/regfile_arb_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
package regfile_arb_pkg;

  localparam int XLEN_DEF = 32;
  localparam int AW_DEF   = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [AW_DEF-1:0]   rd;
    logic [XLEN_DEF-1:0] data;
  } pend_entry_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_chk.sv
// Protocol checks for the write-port arbiter: illegal pipeline writes,
// unexpected long-latency results and FIFO overflow.
module regfile_wr_arbiter_chk #(
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input logic             clk,
  input logic             rst,
  input logic             pipe_wr_en,
  input logic [AW-1:0]    pipe_waddr,
  input logic             mc_valid,
  input logic [AW-1:0]    mc_rd,
  input logic             fifo_push,
  input logic             fifo_full,
  input logic [NREGS-1:0] busy
);

  a_pipe_wr_busy: assert property (@(posedge clk) disable iff (!rst)
    !(pipe_wr_en && (pipe_waddr != {AW{1'b0}}) && busy[pipe_waddr]));

  a_mc_valid_not_busy: assert property (@(posedge clk) disable iff (!rst)
    !(mc_valid && (mc_rd != {AW{1'b0}}) && !busy[mc_rd]));

  a_push_full: assert property (@(posedge clk) disable iff (!rst)
    !(fifo_push && fifo_full));

endmodule

// File: rtl/wb_pend_fifo.sv
// Small synchronous FIFO holding long-latency results until they win the
// register-file write port. Push while full and pop while empty are ignored.
module wb_pend_fifo
  import regfile_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  pend_entry_t din,
  output pend_entry_t head,
  output logic        full,
  output logic        empty,
  output logic [PW:0] count
);

  pend_entry_t mem_r [DEPTH];
  logic [PW:0] wr_ptr_r;
  logic [PW:0] rd_ptr_r;
  logic        do_push_s;
  logic        do_pop_s;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count     = wr_ptr_r - rd_ptr_r;
  assign full      = (count == (PW+1)'(DEPTH));
  assign empty     = (count == {(PW+1){1'b0}});
  assign head      = mem_r[rd_ptr_r[PW-1:0]];
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // Read/write pointer advance; reset discards all contents.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r <= {(PW+1){1'b0}};
      rd_ptr_r <= {(PW+1){1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + {{PW{1'b0}}, 1'b1};
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + {{PW{1'b0}}, 1'b1};
    end
  end

  // Entry storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r[PW-1:0]] <= din;
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. buffered
// long-latency results, with a busy scoreboard for decode hazards and a
// forced drain slot after repeated starvation.
// Optional statistics outputs are enabled by defining REGFILE_ARB_STATS_EN.
module regfile_wr_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int NREGS        = 32,
  parameter int AW           = AW_DEF,
  parameter int PEND_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pipe_wr_en,
  input  logic [AW-1:0]   pipe_waddr,
  input  logic [XLEN-1:0] pipe_wdata,
  input  logic            mc_issue,
  input  logic [AW-1:0]   mc_issue_rd,
  input  logic            mc_valid,
  input  logic [AW-1:0]   mc_rd,
  input  logic [XLEN-1:0] mc_wdata,
  output logic            mc_ready,
  input  logic [AW-1:0]   dec_rs1,
  input  logic [AW-1:0]   dec_rs2,
  input  logic [AW-1:0]   dec_rd,
  output logic            dec_stall,
  output logic            wb_hold,
`ifdef REGFILE_ARB_STATS_EN
  output logic [15:0]     stat_conflicts,
  output logic [15:0]     stat_forced,
`endif
  output logic            reg_wr,
  output logic [AW-1:0]   waddr,
  output logic [XLEN-1:0] wdata
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int CW = $clog2(PEND_DEPTH) + 1;

  arb_state_t     state_r;
  arb_state_t     state_nxt_s;
  logic [SW-1:0]  starve_r;
  logic [SW-1:0]  starve_nxt_s;
  logic [NREGS-1:0] busy_r;
  logic [NREGS-1:0] busy_nxt_s;
  logic [NREGS-1:0] set_mask_s;
  logic [NREGS-1:0] clr_mask_s;

  pend_entry_t    push_entry_s;
  pend_entry_t    head_s;
  logic           fifo_full_s;
  logic           fifo_empty_s;
  logic [CW-1:0]  fifo_count_s;
  logic           push_s;
  logic           pop_s;
  logic           pipe_req_s;
  logic           pipe_win_s;

  assign push_entry_s.rd   = mc_rd;
  assign push_entry_s.data = mc_wdata;

  // Results to x0 are acknowledged but never buffered.
  assign push_s     = rst & mc_valid & ~fifo_full_s & (mc_rd != {AW{1'b0}});
  assign pipe_req_s = pipe_wr_en & (pipe_waddr != {AW{1'b0}});
  assign mc_ready   = rst ? ~fifo_full_s : 1'b1;
  assign wb_hold    = rst & (state_r == FORCE);
  assign dec_stall  = rst & (busy_r[dec_rs1] | busy_r[dec_rs2] | busy_r[dec_rd]);

  wb_pend_fifo #(.DEPTH(PEND_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (push_entry_s),
    .head  (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Port mux: forced drain, then pipeline, then buffered result.
  always_comb begin
    reg_wr     = 1'b0;
    waddr      = {AW{1'b0}};
    wdata      = {XLEN{1'b0}};
    pop_s      = 1'b0;
    pipe_win_s = 1'b0;
    if (!rst) begin
      reg_wr = 1'b0;
    end else if (state_r == FORCE) begin
      reg_wr = ~fifo_empty_s & (head_s.rd != {AW_DEF{1'b0}});
      waddr  = head_s.rd;
      wdata  = head_s.data;
      pop_s  = ~fifo_empty_s;
    end else if (pipe_req_s) begin
      reg_wr     = 1'b1;
      waddr      = pipe_waddr;
      wdata      = pipe_wdata;
      pipe_win_s = ~fifo_empty_s;
    end else if (!fifo_empty_s) begin
      reg_wr = 1'b1;
      waddr  = head_s.rd;
      wdata  = head_s.data;
      pop_s  = 1'b1;
    end else begin
      reg_wr = 1'b0;
    end
  end

  // Next-state and starvation-count logic.
  always_comb begin
    state_nxt_s  = state_r;
    starve_nxt_s = starve_r;
    case (state_r)
      IDLE: begin
        starve_nxt_s = {SW{1'b0}};
        if (push_s) state_nxt_s = PEND;
        else        state_nxt_s = IDLE;
      end
      PEND: begin
        if (pipe_win_s && (starve_r == SW'(STARVE_LIMIT - 1))) begin
          state_nxt_s  = FORCE;
          starve_nxt_s = {SW{1'b0}};
        end else if (pop_s) begin
          starve_nxt_s = {SW{1'b0}};
          if ((fifo_count_s == CW'(1)) && !push_s) state_nxt_s = IDLE;
          else                                     state_nxt_s = PEND;
        end else if (pipe_win_s) begin
          starve_nxt_s = starve_r + {{(SW-1){1'b0}}, 1'b1};
        end else begin
          state_nxt_s = PEND;
        end
      end
      FORCE: begin
        starve_nxt_s = {SW{1'b0}};
        if ((fifo_count_s > CW'(1)) || push_s) state_nxt_s = PEND;
        else                                   state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s  = IDLE;
        starve_nxt_s = {SW{1'b0}};
      end
    endcase
  end

  // Scoreboard update: a write of the head clears, an issue sets (set wins).
  assign clr_mask_s = pop_s ? ({{(NREGS-1){1'b0}}, 1'b1} << head_s.rd) : {NREGS{1'b0}};
  assign set_mask_s = (mc_issue && (mc_issue_rd != {AW{1'b0}}))
                    ? ({{(NREGS-1){1'b0}}, 1'b1} << mc_issue_rd) : {NREGS{1'b0}};
  assign busy_nxt_s = ((busy_r & ~clr_mask_s) | set_mask_s) & ~{{(NREGS-1){1'b0}}, 1'b1};

  // State, starvation counter and scoreboard registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r  <= IDLE;
      starve_r <= {SW{1'b0}};
      busy_r   <= {NREGS{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      starve_r <= starve_nxt_s;
      busy_r   <= busy_nxt_s;
    end
  end

`ifdef REGFILE_ARB_STATS_EN
  logic [15:0] stat_conflicts_r;
  logic [15:0] stat_forced_r;

  // Saturating counters of pipe/FIFO conflicts and forced drain cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_conflicts_r <= 16'd0;
      stat_forced_r    <= 16'd0;
    end else begin
      if (pipe_req_s && !fifo_empty_s) stat_conflicts_r <= sat_inc16(stat_conflicts_r);
      if (state_r == FORCE)            stat_forced_r    <= sat_inc16(stat_forced_r);
    end
  end

  assign stat_conflicts = stat_conflicts_r;
  assign stat_forced    = stat_forced_r;
`endif

  regfile_wr_arbiter_chk #(.NREGS(NREGS), .AW(AW)) u_chk (
    .clk        (clk),
    .rst        (rst),
    .pipe_wr_en (pipe_wr_en),
    .pipe_waddr (pipe_waddr),
    .mc_valid   (mc_valid),
    .mc_rd      (mc_rd),
    .fifo_push  (push_s),
    .fifo_full  (fifo_full_s),
    .busy       (busy_r)
  );

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_regfile_wr_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_wr_en;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        mc_issue;
  logic [4:0]  mc_issue_rd;
  logic        mc_valid;
  logic [4:0]  mc_rd;
  logic [31:0] mc_wdata;
  logic        mc_ready;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_stall;
  logic        wb_hold;
  logic        reg_wr;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  regfile_wr_arbiter #(
    .XLEN(32), .NREGS(32), .AW(5), .PEND_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .pipe_wr_en(pipe_wr_en), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .mc_issue(mc_issue), .mc_issue_rd(mc_issue_rd),
    .mc_valid(mc_valid), .mc_rd(mc_rd), .mc_wdata(mc_wdata), .mc_ready(mc_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_stall(dec_stall),
    .wb_hold(wb_hold), .reg_wr(reg_wr), .waddr(waddr), .wdata(wdata)
  );

  always #5 clk = ~clk;

  // Reference model: pending results in arrival order, busy flags, and the
  // number of consecutive cycles the pipeline beat a non-empty queue.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  bit   busy_m [32];
  int   losses;
  bit   accepted;
  bit   last_force;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int r = 0; r < 32; r++) busy_m[r] = 1'b0;
    losses     = 0;
    accepted   = 1'b0;
    last_force = 1'b0;
  endtask

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic cycle();
    logic        e_wr, e_hold, e_ready, e_stall, do_pop, pipe_won;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    ent_t        ne;
    @(negedge clk);
    e_wr = 1'b0; e_addr = 5'd0; e_data = 32'd0; do_pop = 1'b0;
    if (!rst) begin
      e_hold = 1'b0; e_ready = 1'b1; e_stall = 1'b0;
    end else begin
      e_ready = (q.size() < DEPTH);
      e_stall = busy_m[dec_rs1] | busy_m[dec_rs2] | busy_m[dec_rd];
      e_hold  = (losses == LIMIT);
      if (e_hold) begin
        e_wr = 1'b1; e_addr = q[0].rd; e_data = q[0].data; do_pop = 1'b1;
      end else if (pipe_wr_en && pipe_waddr != 5'd0) begin
        e_wr = 1'b1; e_addr = pipe_waddr; e_data = pipe_wdata;
      end else if (q.size() > 0) begin
        e_wr = 1'b1; e_addr = q[0].rd; e_data = q[0].data; do_pop = 1'b1;
      end
    end
    chk("reg_wr", reg_wr, e_wr);
    if (e_wr || !rst) begin
      chk("waddr", waddr, e_addr);
      chk("wdata", wdata, e_data);
    end
    chk("wb_hold", wb_hold, e_hold);
    chk("mc_ready", mc_ready, e_ready);
    chk("dec_stall", dec_stall, e_stall);
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      pipe_won   = !e_hold && pipe_wr_en && (pipe_waddr != 5'd0) && (q.size() > 0);
      accepted   = mc_valid && e_ready;
      last_force = e_hold;
      if (do_pop) begin
        busy_m[q[0].rd] = 1'b0;
        void'(q.pop_front());
        losses = 0;
      end else if (pipe_won) begin
        losses++;
      end
      if (accepted && mc_rd != 5'd0) begin
        ne.rd = mc_rd; ne.data = mc_wdata;
        q.push_back(ne);
      end
      if (mc_issue && mc_issue_rd != 5'd0) busy_m[mc_issue_rd] = 1'b1;
    end
    #1;
  endtask

  function automatic logic [4:0] pick_free(input logic [4:0] avoid);
    logic [4:0] r;
    for (int t = 0; t < 64; t++) begin
      r = 5'($urandom_range(31, 1));
      if (!busy_m[r] && r != avoid) return r;
    end
    return 5'd0;
  endfunction

  task automatic idle_inputs();
    pipe_wr_en = 1'b0; pipe_waddr = 5'd0; pipe_wdata = 32'd0;
    mc_issue = 1'b0; mc_issue_rd = 5'd0;
    mc_valid = 1'b0; mc_rd = 5'd0; mc_wdata = 32'd0;
    dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_rd = 5'd0;
  endtask

  logic [4:0] outst[$];
  bit         res_active;
  bit         hold_pipe;

  initial begin
    model_reset();
    idle_inputs();
    rst = 1'b0;

    // Reset then idle.
    cycle(); cycle();
    rst = 1'b1;
    cycle(); cycle();

    // Pipe-only traffic, including a write to x0.
    pipe_wr_en = 1'b1; pipe_waddr = 5'd5; pipe_wdata = 32'hDEADBEEF;
    cycle();
    pipe_waddr = 5'd0;
    cycle();
    idle_inputs();

    // Scoreboard set, result writeback, clear.
    mc_issue = 1'b1; mc_issue_rd = 5'd7;
    cycle();
    mc_issue = 1'b0; dec_rs1 = 5'd7;
    mc_valid = 1'b1; mc_rd = 5'd7; mc_wdata = 32'h00001234;
    cycle();
    mc_valid = 1'b0;
    cycle();
    cycle();
    idle_inputs();

    // Starvation: one buffered result vs. continuous pipeline writes.
    mc_issue = 1'b1; mc_issue_rd = 5'd9;
    cycle();
    mc_issue = 1'b0;
    pipe_wr_en = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'hA5A5_0003;
    mc_valid = 1'b1; mc_rd = 5'd9; mc_wdata = 32'h0000_0909;
    cycle();
    mc_valid = 1'b0;
    for (int k = 0; k < 6; k++) cycle();
    idle_inputs();
    cycle();

    // Full FIFO with a held third result.
    for (int k = 10; k < 13; k++) begin
      mc_issue = 1'b1; mc_issue_rd = 5'(k);
      cycle();
    end
    mc_issue = 1'b0;
    pipe_wr_en = 1'b1; pipe_waddr = 5'd4; pipe_wdata = 32'h4444_4444;
    mc_valid = 1'b1; mc_rd = 5'd10; mc_wdata = 32'h1010_1010;
    cycle();
    mc_rd = 5'd11; mc_wdata = 32'h1111_1111;
    cycle();
    mc_rd = 5'd12; mc_wdata = 32'h1212_1212;
    accepted = 1'b0;
    for (int k = 0; k < 12 && !accepted; k++) cycle();
    idle_inputs();
    for (int k = 0; k < 6; k++) cycle();

    // Mid-operation reset with two buffered results and busy bits set.
    mc_issue = 1'b1; mc_issue_rd = 5'd13;
    cycle();
    mc_issue_rd = 5'd14;
    cycle();
    mc_issue = 1'b0;
    pipe_wr_en = 1'b1; pipe_waddr = 5'd4; pipe_wdata = 32'h0BAD_0004;
    mc_valid = 1'b1; mc_rd = 5'd13; mc_wdata = 32'h1313_1313;
    cycle();
    mc_rd = 5'd14; mc_wdata = 32'h1414_1414;
    cycle();
    idle_inputs();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    dec_rs1 = 5'd13; dec_rs2 = 5'd14; dec_rd = 5'd13;
    cycle(); cycle();
    idle_inputs();

    // Randomized traffic obeying the issue/result/hold protocol.
    res_active = 1'b0;
    hold_pipe  = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!hold_pipe) begin
        pipe_wr_en = ($urandom_range(2, 0) != 0);
        pipe_waddr = ($urandom_range(7, 0) == 0) ? 5'd0 : pick_free(5'd0);
        pipe_wdata = $urandom;
      end
      mc_issue    = ($urandom_range(3, 0) == 0) && (outst.size() < 6);
      mc_issue_rd = pick_free(pipe_waddr);
      if (!res_active) begin
        if (outst.size() > 0 && $urandom_range(1, 0) == 1) begin
          res_active = 1'b1; mc_rd = outst.pop_front(); mc_wdata = $urandom;
        end else if ($urandom_range(15, 0) == 0) begin
          res_active = 1'b1; mc_rd = 5'd0; mc_wdata = $urandom;
        end
      end
      mc_valid = res_active;
      dec_rs1 = 5'($urandom_range(31, 0));
      dec_rs2 = 5'($urandom_range(31, 0));
      dec_rd  = 5'($urandom_range(31, 0));
      cycle();
      if (mc_issue && mc_issue_rd != 5'd0) outst.push_back(mc_issue_rd);
      if (accepted) res_active = 1'b0;
      hold_pipe = last_force;
    end
    idle_inputs();
    for (int k = 0; k < 8; k++) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
Arbitrates the single register-file write port between pipeline writeback and a long-latency unit (multi-cycle mul/div, loads).
- Buffers long-latency results in a small pending FIFO.
- Keeps a per-register busy scoreboard so decode can stall on RAW/WAW hazards.
- Forces a drain slot when pipeline writes starve the FIFO.
- Drives the register file's reg_wr/waddr/wdata inputs directly.

Parameters:
- XLEN, 32, data width
- NREGS, 32, architectural register count
- AW, 5, register address width ($clog2(NREGS))
- PEND_DEPTH, 2, pending FIFO depth (power of two, >=2)
- STARVE_LIMIT, 4, consecutive lost-arbitration cycles before a forced drain

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low (0 = reset)
- pipe_wr_en  in  1  pipeline writeback write request
- pipe_waddr  in  AW  pipeline writeback destination
- pipe_wdata  in  XLEN  pipeline writeback data
- mc_issue  in  1  long-latency op issued this cycle
- mc_issue_rd  in  AW  destination of the issued op
- mc_valid  in  1  long-latency result valid
- mc_rd  in  AW  result destination
- mc_wdata  in  XLEN  result data
- mc_ready  out  1  FIFO can accept a result
- dec_rs1, dec_rs2, dec_rd  in  AW each  decode-stage operand/destination addresses
- dec_stall  out  1  decode must stall (scoreboard hit)
- wb_hold  out  1  pipeline must hold its WB stage (forced drain)
- reg_wr  out  1  to register file
- waddr  out  AW  to register file
- wdata  out  XLEN  to register file

Behaviour:
- Reset (rst==0 at posedge):
  - FIFO empty; busy all 0; starve counter 0; state IDLE.
  - reg_wr/waddr/wdata driven 0, dec_stall 0, wb_hold 0, mc_ready 1 while rst==0.
- FIFO handshake:
  - mc_ready = !full.
  - A push occurs on mc_valid && mc_ready at posedge.
  - mc_rd==0 is accepted but not pushed.
  - Minimum result-to-port latency is 1 cycle; no same-cycle bypass.
- Port outputs are combinational from state, pipe inputs and FIFO head. Priority:
  1. In FORCE: FIFO head drives the port; pipe_wr_en is ignored. The pipeline re-presents its write next cycle, guaranteed by wb_hold.
  2. Otherwise, pipe_wr_en && pipe_waddr!=0 drives the port.
  3. Otherwise, a non-empty FIFO drives the port from its head, and the entry pops at posedge.
  4. Otherwise reg_wr=0.
- Writes to x0 are never issued; reg_wr is 0 when the selected address is 0.
- States:
  - IDLE: FIFO empty.
    - Goes to PEND on a push.
  - PEND: FIFO non-empty.
    - Each cycle the pipe wins while the FIFO is non-empty, starve counter increments.
    - Each FIFO pop clears the counter.
    - counter==STARVE_LIMIT-1 and the pipe wins again → FORCE.
    - FIFO empty after a pop with no push → IDLE.
  - FORCE: wb_hold=1 (combinational from state).
    - Head pops; counter clears.
    - Next state is PEND if entries remain or a push occurs, else IDLE.
    - Lasts exactly one cycle.
- Scoreboard:
  - busy[mc_issue_rd] set on mc_issue with mc_issue_rd!=0.
  - busy[head.rd] cleared when the head is written to the port.
  - Set and clear of the same index in the same cycle: set wins.
  - busy[0] is constant 0.
- Hazard: dec_stall = busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd]. This is combinational and covers RAW and WAW.
- Illegal conditions (simulation assertions):
  - pipe_wr_en to a busy register.
  - mc_valid for a non-busy rd!=0.
  - Push while full.
- Reset mid-operation: FIFO contents discarded, busy cleared, and the pending write is dropped in the reset cycle.

Optional Feature:
Macro REGFILE_ARB_STATS_EN.
- Defined: adds two outputs, each 16-bit, saturating at 0xFFFF and cleared by reset.
  - stat_conflicts: counts cycles with a pipe write while the FIFO is non-empty.
  - stat_forced: counts FORCE cycles.
- Undefined: neither the ports nor the counters exist; all other behaviour is identical.

Decomposition:
- Package regfile_arb_pkg holds:
  - state enum arb_state_t {IDLE, PEND, FORCE}
  - XLEN and AW defaults
  - struct pend_entry_t {rd, data}
- One sub-module, wb_pend_fifo: synchronous FIFO of pend_entry_t with push/pop/full/empty/head. Same clk and active-low synchronous rst.

Test Plan:
- Reset then idle: rst=0 for 2 cycles → reg_wr=0, mc_ready=1, dec_stall=0. Release rst → all outputs stay 0 with no requests.
- Pipe-only traffic: pipe_wr_en=1, waddr=5, wdata=0xDEADBEEF → same cycle reg_wr=1, waddr=5, wdata=0xDEADBEEF. pipe_waddr=0 → reg_wr=0.
- Scoreboard:
  - mc_issue rd=7 → next cycle dec_rs1=7 gives dec_stall=1.
  - mc_valid rd=7 data=0x1234 with pipe idle → next cycle port writes x7=0x1234.
  - The following cycle dec_stall=0.
- Starvation: one FIFO entry (rd=9) plus pipe_wr_en every cycle, STARVE_LIMIT=4 → 4 pipe writes, then one FORCE cycle with wb_hold=1 and x9 written. wb_hold=0 afterwards.
- Full FIFO: PEND_DEPTH=2, two pushes with pipe busy → mc_ready=0. A third mc_valid is held until a pop, then accepted.
- Mid-operation reset with 2 FIFO entries and busy bits set: rst=0 one cycle → FIFO empty, busy all 0, no write of buffered data.
